// File: rtl/skinny_sbox8_inv_ti2_hs.sv
// SKINNY-128 8-bit inverse S-box as a three-share threshold implementation.
// Eight registered shared-NOR cells form a 4-stage network. A valid/ready
// wrapper holds one masked byte steady while the network settles.

// Shared NOR cell: f = z ^ ~(a|b) on 3-share bits, output registered.
// Each output share reads only two input share indices (non-complete).
module skinny_sbox8_inv_ti2_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [2:0] z,
  output logic [2:0] f
);
  logic [2:0] x, y;

  // Inverting share 0 turns the shared AND into a shared NOR.
  assign x = {a[2], a[1], ~a[0]};
  assign y = {b[2], b[1], ~b[0]};

  // Registered output shares; share k omits input share k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f <= '0;
    end else begin
      f[0] <= (x[1] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[1]) ^ z[0];
      f[1] <= (x[2] & y[2]) ^ (x[0] & y[2]) ^ (x[2] & y[0]) ^ z[1];
      f[2] <= (x[0] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[0]) ^ z[2];
    end
  end
endmodule

module skinny_sbox8_inv_ti2_hs (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] si0,
  input  logic [7:0] si1,
  input  logic [7:0] si2,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] bo0,
  output logic [7:0] bo1,
  output logic [7:0] bo2,
  output logic       out_valid,
  input  logic       out_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, nxt;
  logic [1:0]      cnt;
  logic [2:0][7:0] r;
  logic [2:0]      o  [8];
  logic [2:0]      bc [8];
  logic            accept;

  assign accept = in_valid & (state == IDLE);

  // Input register: written only on accept, held through BUSY and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r <= '0;
    else if (accept) r <= {si2, si1, si0};
  end

  // Regroup the held byte into per-bit share triples.
  always_comb begin
    for (int i = 0; i < 8; i++) o[i] = '0;
    for (int i = 0; i < 8; i++) o[i] = {r[2][i], r[1][i], r[0][i]};
  end

  // Stage 1: depends on the held byte only.
  skinny_sbox8_inv_ti2_cell u_b2 (.clk(clk), .rst(rst), .a(o[3]),  .b(o[1]),  .z(o[0]), .f(bc[2]));
  skinny_sbox8_inv_ti2_cell u_b3 (.clk(clk), .rst(rst), .a(o[7]),  .b(o[6]),  .z(o[4]), .f(bc[3]));
  skinny_sbox8_inv_ti2_cell u_b7 (.clk(clk), .rst(rst), .a(o[2]),  .b(o[7]),  .z(o[1]), .f(bc[7]));
  skinny_sbox8_inv_ti2_cell u_b5 (.clk(clk), .rst(rst), .a(o[6]),  .b(o[5]),  .z(o[7]), .f(bc[5]));
  // Stage 2
  skinny_sbox8_inv_ti2_cell u_b1 (.clk(clk), .rst(rst), .a(o[5]),  .b(bc[3]), .z(o[3]), .f(bc[1]));
  skinny_sbox8_inv_ti2_cell u_b0 (.clk(clk), .rst(rst), .a(bc[3]), .b(bc[2]), .z(o[5]), .f(bc[0]));
  // Stage 3
  skinny_sbox8_inv_ti2_cell u_b6 (.clk(clk), .rst(rst), .a(bc[2]), .b(bc[1]), .z(o[2]), .f(bc[6]));
  // Stage 4
  skinny_sbox8_inv_ti2_cell u_b4 (.clk(clk), .rst(rst), .a(bc[7]), .b(bc[6]), .z(o[6]), .f(bc[4]));

  // Output shares come straight from the cell registers.
  always_comb begin
    bo0 = '0;
    bo1 = '0;
    bo2 = '0;
    for (int i = 0; i < 8; i++) begin
      bo0[i] = bc[i][0];
      bo1[i] = bc[i][1];
      bo2[i] = bc[i][2];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Settle counter: cleared on accept, counts while BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == BUSY) cnt <= cnt + 2'd1;
  end

  // Next-state logic: four edges after accept the deepest cell is final.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid)     nxt = BUSY;
      BUSY:    if (cnt == 2'd3)  nxt = DONE;
      DONE:    if (out_ready)    nxt = IDLE;
      default:                   nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end
endmodule
